// File: rtl/softmax_result_reporter.sv
// Final inference stage: picks the arg-max class of the softmax vector, strobes the
// result, then streams a 5-byte framed record (sync, class, conf hi/lo, xor) to the host link.
module softmax_result_reporter #(
  parameter int          N_CLASSES   = 10,
  parameter int          W           = 16,
  parameter int unsigned CONF_THRESH = 'h4000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLASSES*W-1:0] probs,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             class_idx,
  output logic [W-1:0]           confidence,
  output logic                   low_conf,
  output logic                   result_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, SEND} state_e;

  state_e             state_q;
  logic [15:0][W-1:0] vec_d, vec_q;
  logic [3:0]         count_q;
  logic [W-1:0]       best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [3:0]         class_idx_q;
  logic [W-1:0]       conf_q;
  logic               low_conf_q;
  logic               result_valid_q;
  logic [2:0]         byte_idx_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;

  logic [W-1:0] cur;
  logic         gt;
  logic [15:0]  conf16;
  logic [7:0]   b1, b2, b3, b4, next_byte;

  // Unused upper slots stay zero so the 4-bit scan index never reads garbage.
  always_comb begin
    vec_d = '0;
    for (int i = 0; i < N_CLASSES; i++) vec_d[i] = probs[i*W +: W];
  end

  // Strict greater-than keeps the lowest index on ties.
  assign cur        = vec_q[count_q];
  assign gt         = cur > best_q;
  assign best_d     = gt ? cur : best_q;
  assign best_idx_d = gt ? count_q : best_idx_q;

  assign conf16 = 16'(conf_q);
  assign b1     = {low_conf_q, 3'b000, class_idx_q};
  assign b2     = conf16[15:8];
  assign b3     = conf16[7:0];
  assign b4     = b1 ^ b2 ^ b3;

  // Byte that follows the one currently presented.
  always_comb begin
    case (byte_idx_q)
      3'd0:    next_byte = b1;
      3'd1:    next_byte = b2;
      3'd2:    next_byte = b3;
      default: next_byte = b4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      count_q        <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      class_idx_q    <= '0;
      conf_q         <= '0;
      low_conf_q     <= 1'b0;
      result_valid_q <= 1'b0;
      byte_idx_q     <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q      <= vec_d;
            count_q    <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          count_q    <= count_q + 4'd1;
          if (count_q == 4'(N_CLASSES - 1)) begin
            class_idx_q    <= best_idx_d;
            conf_q         <= best_d;
            low_conf_q     <= best_d < W'(CONF_THRESH);
            result_valid_q <= 1'b1;
            byte_idx_q     <= '0;
            tx_valid_q     <= 1'b1;
            tx_data_q      <= SYNC_BYTE;
            state_q        <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_idx_q == 3'd4) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              state_q    <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 3'd1;
              tx_data_q  <= next_byte;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign class_idx    = class_idx_q;
  assign confidence   = conf_q;
  assign low_conf     = low_conf_q;
  assign result_valid = result_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

endmodule
